// File: rtl/seq_mult_unit.sv
// Iterative shift-and-add multiplier for MULT/MULTU: one operand pair in,
// 64-bit {HI, LO} product out after 32 RUN cycles, with busy/done handshake.
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           funct,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     mcand_reg, mcand_next;
    logic [WIDTH-1:0]     mplier_reg, mplier_next;
    logic                 neg_reg, neg_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;
    logic [CW-1:0]        count_reg, count_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;

    logic                 valid_op;
    logic                 is_signed;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;

    always_comb begin
        valid_op  = (funct == F_MULT) || (funct == F_MULTU);
        is_signed = (funct == F_MULT);
        // Unsigned negation turns 0x80000000 into 2^31, which fits exactly.
        mag_a     = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
        mag_b     = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;
        addend    = {{WIDTH{1'b0}}, mcand_reg} << count_reg;
        acc_sum   = acc_reg + (mplier_reg[0] ? addend : '0);
    end

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        neg_next     = neg_reg;
        acc_next     = acc_reg;
        count_next   = count_reg;
        product_next = product_reg;

        case (state_reg)
            // The DONE->IDLE edge also accepts a new request, giving a
            // 33-cycle initiation interval when start is held high.
            IDLE, DONE: begin
                if (state_reg == DONE) begin
                    state_next = IDLE;
                end
                if (start && valid_op) begin
                    mcand_next  = mag_a;
                    mplier_next = mag_b;
                    neg_next    = is_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                    acc_next    = '0;
                    count_next  = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                acc_next    = acc_sum;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg + 1'b1;
                if (count_reg == CW'(WIDTH - 1)) begin
                    product_next = neg_reg ? -acc_sum : acc_sum;
                    state_next   = DONE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            neg_reg     <= 1'b0;
            acc_reg     <= '0;
            count_reg   <= '0;
            product_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            neg_reg     <= neg_next;
            acc_reg     <= acc_next;
            count_reg   <= count_next;
            product_reg <= product_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed plus random stimulus for seq_mult_unit, checked cycle by cycle
// against a plain 64-bit arithmetic reference.
module tb_seq_mult_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int          checks;
    int          errors;
    logic [63:0] prev_product;

    seq_mult_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct   (funct),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ref_mult(input logic [5:0] f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (f == F_MULT) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one accepted operation and checks busy/done/product at every
    // cycle from the accept edge until one cycle after return to IDLE.
    // If inj_n >= 0, a MULTU 2*3 request is raised during that RUN cycle.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int inj_n, input string tag);
        logic [63:0] exp;
        exp = ref_mult(f, a, b);
        @(negedge clk);
        start = 1'b1; funct = f; dataA = a; dataB = b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n <= 32; n++) begin
            @(negedge clk);
            chk($sformatf("%s busy n=%0d", tag, n), {63'h0, busy}, 64'd1);
            chk($sformatf("%s done n=%0d", tag, n), {63'h0, done}, {63'h0, n == 32});
            chk($sformatf("%s product n=%0d", tag, n), product, (n == 32) ? exp : prev_product);
            if (n == inj_n) begin
                start = 1'b1; funct = F_MULTU; dataA = 32'd2; dataB = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk({tag, " busy idle"}, {63'h0, busy}, 64'd0);
        chk({tag, " done idle"}, {63'h0, done}, 64'd0);
        chk({tag, " product held"}, product, exp);
        $display("op %s funct=%b a=%h b=%h product=%h expected=%h", tag, f, a, b, product, exp);
        prev_product = exp;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rf;

        checks = 0;
        errors = 0;
        prev_product = 64'h0;
        start = 1'b0;
        funct = 6'h0;
        dataA = 32'h0;
        dataB = 32'h0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #2;
        chk("reset busy", {63'h0, busy}, 64'd0);
        chk("reset done", {63'h0, done}, 64'd0);
        chk("reset product", product, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "multu_max");
        chk("multu_max literal", prev_product, 64'hFFFFFFFE_00000001);
        run_op(F_MULT, 32'hFFFFFFFD, 32'd7, -1, "mult_neg3x7");
        run_op(F_MULT, 32'h80000000, 32'h80000000, -1, "mult_minxmin");
        run_op(F_MULT, 32'd5, 32'd6, 10, "mult_5x6_inj");

        // Reset during RUN: outputs clear without a clock edge.
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; dataA = 32'h1234; dataB = 32'h5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (16) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrun reset busy", {63'h0, busy}, 64'd0);
        chk("midrun reset done", {63'h0, done}, 64'd0);
        chk("midrun reset product", product, 64'h0);
        $display("reset mid-run busy=%b done=%b product=%h", busy, done, product);
        #1 reset = 1'b0;
        prev_product = 64'h0;
        run_op(F_MULTU, 32'd3, 32'd4, -1, "after_reset_3x4");

        // Non-multiply funct is ignored.
        @(negedge clk);
        start = 1'b1; funct = 6'b100000; dataA = 32'd9; dataB = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk($sformatf("badfunct busy n=%0d", n), {63'h0, busy}, 64'd0);
            chk($sformatf("badfunct done n=%0d", n), {63'h0, done}, 64'd0);
            chk($sformatf("badfunct product n=%0d", n), product, prev_product);
        end
        $display("invalid funct busy=%b done=%b product=%h", busy, done, product);

        // start held high: second accept on the DONE->IDLE edge.
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; dataA = 32'd1; dataB = 32'd1;
        @(posedge clk);
        for (int n = 0; n <= 66; n++) begin
            @(negedge clk);
            chk($sformatf("b2b busy n=%0d", n), {63'h0, busy}, {63'h0, n <= 65});
            chk($sformatf("b2b done n=%0d", n), {63'h0, done}, {63'h0, (n == 32) || (n == 65)});
            if (n == 32 || n == 65) chk($sformatf("b2b product n=%0d", n), product, 64'd1);
            if (n == 65) start = 1'b0;
        end
        $display("back-to-back product=%h", product);
        prev_product = 64'd1;

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rf = ($urandom_range(0, 1) == 0) ? F_MULT : F_MULTU;
            run_op(rf, ra, rb, -1, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
